// File: rtl/rr_grant_arbiter_4.sv
// Round-robin arbiter for four requesters with a per-owner tenure limit and an enable gate.
// Produces a registered one-hot grant, the winner index and a grant-valid flag.
module rr_grant_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [1:0]      last_ptr;
    logic [CW-1:0]   hold_cnt;

    logic [1:0]      pick_id;
    logic            pick_any;
    logic            others_req;
    logic [1:0]      idx;

    // First requesting client after last_ptr, scanning upward with wrap-around.
    always_comb begin
        pick_id  = 2'd0;
        pick_any = 1'b0;
        idx      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_ptr + 2'(k);
            if (!pick_any && req[idx]) begin
                pick_id  = idx;
                pick_any = 1'b1;
            end
        end
    end

    assign others_req = |(req & ~(4'b0001 << gnt_id));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            last_ptr  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (en && pick_any) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << pick_id;
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CW'(1);
                        last_ptr  <= pick_id;
                    end
                end
                GRANT: begin
                    if (!en) begin
                        state     <= IDLE;
                        gnt       <= 4'b0000;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end else if (!req[gnt_id]) begin
                        // Release: hand off in the same edge, or park when nobody waits.
                        if (pick_any) begin
                            gnt       <= 4'b0001 << pick_id;
                            gnt_id    <= pick_id;
                            hold_cnt  <= CW'(1);
                            last_ptr  <= pick_id;
                        end else begin
                            state     <= IDLE;
                            gnt       <= 4'b0000;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end else if (hold_cnt < CW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end else if (others_req) begin
                        // Tenure expired with contention; last_ptr equals the holder here.
                        gnt      <= 4'b0001 << pick_id;
                        gnt_id   <= pick_id;
                        hold_cnt <= CW'(1);
                        last_ptr <= pick_id;
                    end else begin
                        hold_cnt <= CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 4'b0000;
                    gnt_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// Bench for rr_grant_arbiter_4: directed scenarios plus random traffic against a reference model.
module tb_rr_grant_arbiter_4;

    localparam int unsigned MH = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int total;
    int bad;

    // reference model: current owner (-1 = none), last winner, tenure count
    int m_owner;
    int m_last;
    int m_cnt;
    int m_id;

    rr_grant_arbiter_4 #(.MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pick_from(input int from, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (from + k) % 4;
            if (r[c]) begin
                m_owner = c;
                m_last  = c;
                m_id    = c;
                m_cnt   = 1;
                return;
            end
        end
    endtask

    task automatic model_edge(input logic r_rst, input logic r_en, input logic [3:0] r);
        if (r_rst) begin
            m_owner = -1; m_last = 3; m_cnt = 0; m_id = 0;
        end else if (m_owner < 0) begin
            if (r_en && r != 4'b0000) pick_from(m_last, r);
        end else if (!r_en) begin
            m_owner = -1; m_cnt = 0;
        end else if (!r[m_owner]) begin
            if (r != 4'b0000) pick_from(m_owner, r);
            else begin m_owner = -1; m_cnt = 0; end
        end else if (m_cnt < int'(MH)) begin
            m_cnt = m_cnt + 1;
        end else if ((r & ~(4'b0001 << m_owner)) != 4'b0000) begin
            pick_from(m_owner, r);
        end else begin
            m_cnt = 1;
        end
    endtask

    task automatic check(input string tag);
        logic [3:0] eg;
        logic [1:0] eid;
        logic       ev;
        eg  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        eid = 2'(m_id);
        ev  = (m_owner >= 0);
        total++;
        assert (gnt === eg) else begin
            bad++;
            $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
        end
        total++;
        assert (gnt_id === eid) else begin
            bad++;
            $error("FAIL %s gnt_id got=%0d exp=%0d", tag, gnt_id, eid);
        end
        total++;
        assert (gnt_valid === ev) else begin
            bad++;
            $error("FAIL %s gnt_valid got=%b exp=%b", tag, gnt_valid, ev);
        end
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] exp);
        total++;
        assert (gnt === exp) else begin
            bad++;
            $error("FAIL %s gnt got=%b exp=%b", tag, gnt, exp);
        end
    endtask

    task automatic step(input string tag, input logic s_rst, input logic s_en, input logic [3:0] s_req);
        @(negedge clk);
        rst = s_rst;
        en  = s_en;
        req = s_req;
        @(posedge clk);
        model_edge(s_rst, s_en, s_req);
        #1;
        check(tag);
    endtask

    initial begin
        logic [3:0] exp_g;
        total = 0;
        bad   = 0;
        m_owner = -1; m_last = 3; m_cnt = 0; m_id = 0;
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;

        // T1 reset holds outputs low even with full requests
        step("t1_rst0", 1'b1, 1'b1, 4'hF);
        step("t1_rst1", 1'b1, 1'b1, 4'hF);
        expect_gnt("t1_rst_const", 4'b0000);
        step("t1_first", 1'b0, 1'b1, 4'hF);
        expect_gnt("t1_first_const", 4'b0001);

        // T2 single client
        step("t2_rst", 1'b1, 1'b0, 4'b0000);
        step("t2_grant", 1'b0, 1'b1, 4'b0100);
        expect_gnt("t2_grant_const", 4'b0100);
        for (int i = 0; i < 3; i++) step("t2_hold", 1'b0, 1'b1, 4'b0100);
        step("t2_release", 1'b0, 1'b1, 4'b0000);
        expect_gnt("t2_release_const", 4'b0000);

        // T3 fairness under full contention
        step("t3_rst", 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 17; i++) begin
            step("t3_rr", 1'b0, 1'b1, 4'hF);
            exp_g = 4'b0001 << ((i / 4) % 4);
            expect_gnt("t3_seq", exp_g);
        end

        // T4 release handoff without a gap
        step("t4_rst", 1'b1, 1'b0, 4'b0000);
        step("t4_own0", 1'b0, 1'b1, 4'b0001);
        step("t4_handoff", 1'b0, 1'b1, 4'b1010);
        expect_gnt("t4_handoff_const", 4'b0010);

        // T5 sole requester keeps grant past tenure
        step("t5_rst", 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            step("t5_sole", 1'b0, 1'b1, 4'b0001);
            expect_gnt("t5_sole_const", 4'b0001);
        end

        // T6 enable gating keeps last_ptr; reset clears it
        step("t6_rst", 1'b1, 1'b0, 4'b0000);
        step("t6_own2", 1'b0, 1'b1, 4'b0100);
        step("t6_en0", 1'b0, 1'b0, 4'b0100);
        expect_gnt("t6_en0_const", 4'b0000);
        step("t6_resume", 1'b0, 1'b1, 4'b0101);
        expect_gnt("t6_resume_const", 4'b0001);
        step("t6_en0_chg", 1'b0, 1'b0, 4'b1111);
        step("t6_rst_own2", 1'b1, 1'b0, 4'b0000);
        step("t6_own2b", 1'b0, 1'b1, 4'b0100);
        step("t6_midrst", 1'b1, 1'b1, 4'b0100);
        expect_gnt("t6_midrst_const", 4'b0000);
        step("t6_after_rst", 1'b0, 1'b1, 4'b0101);
        expect_gnt("t6_after_rst_const", 4'b0001);

        // random traffic with sticky requests so tenure limits get exercised
        for (int i = 0; i < 600; i++) begin
            logic       r_rst;
            logic       r_en;
            logic [3:0] r_req;
            r_rst = ($urandom_range(0, 59) == 0);
            r_en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) r_req = 4'($urandom);
            else r_req = req;
            step("rand", r_rst, r_en, r_req);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
